store_unit: RTL
===============

Name: store_unit

Overview:
- Store-side counterpart of the writeback select path: moves register data toward data memory, where the writeback path moves memory data toward the register file.
- Takes a store request (rs2 data, ALU byte address, funct3) from the execute stage.
- Produces aligned write data and byte enables, and runs a req/ack write handshake with data memory.
- Stalls the pipeline until the write completes, and reports misaligned, illegal and timed-out stores.

Parameters:
ADDR_W, 10, byte address width (matches 10-bit pc/address space)
TIMEOUT, 15, max cycles in REQ waiting for mem_ack before fault

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
store_en  input  1  store instruction valid; held high by pipeline while stall=1
funct3  input  3  000=SB, 001=SH, 010=SW; others illegal
addr  input  ADDR_W  byte address from ALU result
rs2_data  input  32  Reg[rs2] from register file
mem_ack  input  1  memory accepted the write; sampled only in REQ
mem_we  output  1  write request to data memory (registered)
mem_addr  output  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00} (registered)
mem_wdata  output  32  lane-replicated store data (registered)
mem_be  output  4  byte enables (registered)
stall  output  1  hold PC/pipeline (combinational)
done  output  1  one-cycle pulse, store committed
fault  output  2  one-cycle code: 0 none, 1 misaligned, 2 illegal funct3, 3 timeout

Behaviour:
- States: IDLE, REQ, DONE.
- Reset (rst_n=0 at an edge, any state including REQ): state=IDLE; mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, done=0, fault=0; timeout counter=0. The in-flight write is dropped and no done is issued.
- Legality check in IDLE when store_en=1:
  - funct3 not in {000,001,010}: fault=2 next cycle, stay IDLE, no memory access.
  - SH with addr[0]=1, or SW with addr[1:0]!=0: fault=1 next cycle, stay IDLE, no memory access.
  - Illegal funct3 takes priority over misalignment.
- Legal request in IDLE: latch outputs and go to REQ; mem_we=1 from the first REQ cycle.
  - SB: mem_wdata={4{rs2_data[7:0]}}, mem_be=4'b0001<<addr[1:0].
  - SH: mem_wdata={2{rs2_data[15:0]}}, mem_be = addr[1] ? 4'b1100 : 4'b0011.
  - SW: mem_wdata=rs2_data, mem_be=4'b1111.
- REQ:
  - Outputs held stable; counter increments each cycle.
  - mem_ack=1: go to DONE, mem_we=0 next cycle.
  - Counter reaches TIMEOUT with no ack: fault=3 for one cycle, mem_we=0, go to IDLE, no done.
  - Ack on the same edge as the TIMEOUT-th cycle: ack wins.
- DONE: done=1 for this cycle only; store_en ignored; go to IDLE next cycle. The counter clears on leaving REQ.
- stall = (IDLE & store_en & legal) | REQ. It is low in DONE and low on fault cycles, so the pipeline advances at the edge ending DONE.
- Latency: minimum 3 cycles from acceptance to IDLE (IDLE→REQ with ack in first REQ cycle→DONE→IDLE). stall is high for 1+N cycles, where N = REQ cycles.
- mem_ack is ignored in IDLE and DONE.
- store_en=0 in IDLE: no state change, all outputs idle.
- Sequential stores: a new store presented in the cycle after DONE is accepted normally.

Test Plan:
- Reset then SW, addr=0x008, rs2=0xDEADBEEF, ack on first REQ cycle → mem_addr=0x008, mem_wdata=0xDEADBEEF, mem_be=1111, mem_we for 1 cycle, done on cycle 3, stall high cycles 1–2 only.
- SB addr=0x013, rs2=0x000000A5; ack after 3 REQ cycles → mem_addr=0x010, mem_wdata=0xA5A5A5A5, mem_be=1000, mem_we high 3 cycles, single done pulse.
- SH addr=0x006, rs2=0x00001234 → mem_be=1100, mem_wdata=0x12341234. Then SH addr=0x005 → fault=1, mem_we stays 0, no done.
- funct3=011 with addr=0x001 → fault=2 (not 1), no memory access. SW addr=0x002 → fault=1.
- Legal SW with mem_ack held 0 → mem_we high exactly TIMEOUT=15 cycles, then fault=3, stall drops, no done. Repeat with ack in the 15th cycle → done, no fault.
- rst_n=0 for one edge in the second REQ cycle → all outputs 0 next cycle, no done. A later ack pulse is ignored, and the next SW completes normally.

Source files
------------

// File: rtl/store_unit.sv
// Store path to data memory: aligns rs2 data into byte lanes, raises byte enables,
// runs the req/ack write handshake and flags misaligned, illegal and timed-out stores.
module store_unit #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              store_en,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       rs2_data,
  input  logic              mem_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              stall,
  output logic              done,
  output logic [1:0]        fault
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [1:0] FAULT_NONE  = 2'd0;
  localparam logic [1:0] FAULT_ALIGN = 2'd1;
  localparam logic [1:0] FAULT_ILL   = 2'd2;
  localparam logic [1:0] FAULT_TMO   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic              r_done;
  logic [1:0]        r_fault;

  logic              w_illegal;
  logic              w_misalign;
  logic              w_legal;
  logic              w_timeout;
  logic [31:0]       w_wdata;
  logic [3:0]        w_be;

  // Request classification; illegal funct3 masks the alignment check.
  assign w_illegal  = (funct3 > F3_SW);
  assign w_misalign = ((funct3 == F3_SH) && addr[0]) ||
                      ((funct3 == F3_SW) && (addr[1:0] != 2'b00));
  assign w_legal    = !w_illegal && !w_misalign;
  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Lane replication and byte-enable generation for the accepted size.
  always_comb begin
    w_wdata = rs2_data;
    w_be    = 4'b1111;
    case (funct3)
      F3_SB: begin
        w_wdata = {4{rs2_data[7:0]}};
        w_be    = 4'b0001 << addr[1:0];
      end
      F3_SH: begin
        w_wdata = {2{rs2_data[15:0]}};
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wdata = rs2_data;
        w_be    = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_done  <= 1'b0;
      r_fault <= FAULT_NONE;
    end else begin
      r_done  <= 1'b0;
      r_fault <= FAULT_NONE;
      case (r_state)
        S_IDLE: begin
          if (store_en) begin
            if (w_illegal) begin
              r_fault <= FAULT_ILL;
            end else if (w_misalign) begin
              r_fault <= FAULT_ALIGN;
            end else begin
              r_state <= S_REQ;
              r_cnt   <= '0;
              r_we    <= 1'b1;
              r_addr  <= {addr[ADDR_W-1:2], 2'b00};
              r_wdata <= w_wdata;
              r_be    <= w_be;
            end
          end
        end
        S_REQ: begin
          // Ack beats the timeout when both land on the same edge.
          if (mem_ack || w_timeout) begin
            r_state <= mem_ack ? S_DONE : S_IDLE;
            r_done  <= mem_ack;
            r_fault <= mem_ack ? FAULT_NONE : FAULT_TMO;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign stall     = ((r_state == S_IDLE) && store_en && w_legal) || (r_state == S_REQ);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_be    = r_be;
  assign done      = r_done;
  assign fault     = r_fault;

endmodule
